// File: rtl/fp_mult_uc_pkg.sv
// fp_mult_uc_pkg: shared states, control-word constants and normalization word helper for fp_mult_uc
package fp_mult_uc_pkg;
  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    CARREGA     = 3'd1,
    MULTIPLICA  = 3'd2,
    NORMALIZA   = 3'd3,
    ARREDONDA   = 3'd4,
    VERIFICA    = 3'd5,
    RENORMALIZA = 3'd6,
    FIM         = 3'd7
  } state_e;
  localparam int SHIFT_LEFT = 8;
  localparam int INC_DEC = 8;
  localparam logic [8:0] RIGHT1 = 9'b0_00000001;
  localparam logic [8:0] INC1 = 9'b0_00000001;
  function automatic logic [8:0] norm_word(input int p, input int hidden);
    logic [8:0] w;
    w = '0;
    w[SHIFT_LEFT] = 1'b1;
    w[7:0] = 8'(hidden - p);
    return p > hidden ? RIGHT1 : p == hidden ? 9'h000 : w;
  endfunction
endpackage

// File: rtl/fp_mult_uc_detector_um.sv
// detector_um: leading-one detector (vec_i -> pos_o index of highest set bit, zero_o when vec_i is all zero)
module detector_um
  import fp_mult_uc_pkg::*;
#(
  parameter int W  = 54,
  parameter int PW = $clog2(W)
) (
  input  logic [W-1:0]  vec_i,
  output logic [PW-1:0] pos_o,
  output logic          zero_o
);
  always_comb begin
    pos_o = '0;
    for (int i = 0; i < W; i++) if (vec_i[i]) pos_o = PW'(i);
  end
  assign zero_o = ~|vec_i;
endmodule

// File: rtl/fp_mult_uc.sv
// fp_mult_uc: FP multiplier control FSM (in: clock, reset, iniciar, ula, round_fract; out: fd control words, ocupado, pronto, resultado_zero)
module fp_mult_uc
  import fp_mult_uc_pkg::*;
#(
  parameter int ULA_W      = 54,
  parameter int FRAC_W     = 26,
  parameter int HIDDEN_POS = 46,
  parameter int MULT_LAT   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ULA_W-1:0]  ula,
  input  logic [FRAC_W-1:0] round_fract,
  output logic              sinalMuxFP1,
  output logic              sinalMuxFP2,
  output logic [8:0]        sinalShiftRes,
  output logic [8:0]        sinalIncOrDec,
  output logic              sinalRound,
  output logic              ocupado,
  output logic              pronto,
  output logic              resultado_zero
);
  localparam int PW = $clog2(ULA_W);
  localparam int CW = MULT_LAT > 1 ? $clog2(MULT_LAT) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0] word_q, word_d;
  logic [PW-1:0] pos;
  logic zero, last, unused_frac;
  detector_um #(.W(ULA_W)) u_det (
    .vec_i (ula),
    .pos_o (pos),
    .zero_o(zero)
  );
  assign unused_frac = ^round_fract[FRAC_W-2:0];
  assign last = cnt_q == CW'(MULT_LAT - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO:      state_d = iniciar ? CARREGA : OCIOSO;
      CARREGA:     state_d = MULTIPLICA;
      MULTIPLICA:  state_d = !last ? MULTIPLICA : zero ? FIM : NORMALIZA;
      NORMALIZA:   state_d = ARREDONDA;
      ARREDONDA:   state_d = VERIFICA;
      VERIFICA:    state_d = round_fract[FRAC_W-1] ? RENORMALIZA : FIM;
      RENORMALIZA: state_d = FIM;
      FIM:         state_d = OCIOSO;
      default:     state_d = OCIOSO;
    endcase
    cnt_d = (state_q == MULTIPLICA && !last) ? cnt_q + CW'(1) : '0;
    word_d = (state_q == MULTIPLICA && last && !zero) ? norm_word(int'(pos), HIDDEN_POS) : word_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= OCIOSO;
      cnt_q          <= '0;
      word_q         <= '0;
      sinalMuxFP1    <= 1'b0;
      sinalMuxFP2    <= 1'b0;
      sinalShiftRes  <= '0;
      sinalIncOrDec  <= '0;
      sinalRound     <= 1'b0;
      ocupado        <= 1'b0;
      pronto         <= 1'b0;
      resultado_zero <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      word_q         <= word_d;
      sinalMuxFP1    <= state_d inside {NORMALIZA, RENORMALIZA};
      sinalMuxFP2    <= state_d == RENORMALIZA;
      sinalShiftRes  <= state_d == NORMALIZA ? word_d : state_d == RENORMALIZA ? RIGHT1 : '0;
      sinalIncOrDec  <= state_d == NORMALIZA ? word_d : state_d == RENORMALIZA ? INC1 : '0;
      sinalRound     <= state_d == ARREDONDA;
      ocupado        <= state_d != OCIOSO;
      pronto         <= state_d == FIM;
      resultado_zero <= state_d == FIM && state_q == MULTIPLICA && zero;
    end
  end
endmodule

// File: tb/tb_fp_mult_uc.sv
// tb_fp_mult_uc: scoreboard bench for fp_mult_uc with a behavioural model of one multiply run
module tb_fp_mult_uc;
  logic clock = 0, reset = 1, iniciar = 0;
  logic [53:0] ula = '0;
  logic [25:0] round_fract = '0;
  logic sinalMuxFP1, sinalMuxFP2, sinalRound, ocupado, pronto, resultado_zero;
  logic [8:0] sinalShiftRes, sinalIncOrDec;
  fp_mult_uc dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .ula(ula), .round_fract(round_fract),
    .sinalMuxFP1(sinalMuxFP1), .sinalMuxFP2(sinalMuxFP2), .sinalShiftRes(sinalShiftRes),
    .sinalIncOrDec(sinalIncOrDec), .sinalRound(sinalRound), .ocupado(ocupado),
    .pronto(pronto), .resultado_zero(resultado_zero)
  );
  always #5 clock = ~clock;
  typedef struct {
    bit zero;
    int lat;
    logic [8:0] word;
    bit renorm;
    int rnd;
    int mux1;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int pass = 0, total = 0;
  task automatic chk(input string n, input longint unsigned a, input longint unsigned x);
    total++;
    if (a == x) pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
  endtask
  // Expected behaviour of one run: latency counted from the first busy cycle (=1) to the pronto cycle.
  function automatic exp_t model(input logic [53:0] u, input logic [25:0] rf);
    exp_t m;
    int p = -1;
    for (int i = 0; i < 54; i++) if ({10'd0, u} >= (64'd1 << i)) p = i;
    m.zero = (u == 0);
    m.renorm = !m.zero && rf[25];
    m.lat = m.zero ? 3 : 6 + int'(m.renorm);
    m.rnd = m.zero ? 0 : 1;
    m.mux1 = m.zero ? 0 : 1 + int'(m.renorm);
    m.word = (m.zero || p == 46) ? 9'h000 : p > 46 ? 9'h001 : 9'h100 + 9'(46 - p);
    return m;
  endfunction
  int cyc = 0, nmux1 = 0, nround = 0;
  logic [8:0] nw_s = 0, nw_i = 0, rw_s = 0, rw_i = 0;
  bit busy_prev = 0, after_pronto = 0;
  always @(negedge clock) begin
    if (after_pronto) begin
      chk("idle_after_pronto", ocupado, 0);
      after_pronto = 0;
    end
    if (ocupado && !busy_prev) begin
      cyc = 0; nmux1 = 0; nround = 0; nw_s = 0; nw_i = 0; rw_s = 0; rw_i = 0;
    end
    busy_prev = ocupado;
    if (ocupado) begin
      cyc++;
      if (sinalMuxFP1) nmux1++;
      if (sinalRound) nround++;
      if (sinalMuxFP1 && !sinalMuxFP2) begin nw_s = sinalShiftRes; nw_i = sinalIncOrDec; end
      if (sinalMuxFP2) begin rw_s = sinalShiftRes; rw_i = sinalIncOrDec; end
    end
    if (resultado_zero && !pronto) chk("zero_outside_fim", 1, 0);
    if (pronto) begin
      after_pronto = 1;
      if (q.size() == 0) chk("unexpected_pronto", 1, 0);
      else begin
        e = q.pop_front();
        chk("resultado_zero", resultado_zero, e.zero);
        chk("latency", cyc, e.lat);
        chk("norm_shift", nw_s, e.word);
        chk("norm_inc", nw_i, e.word);
        chk("mux1_cycles", nmux1, e.mux1);
        chk("round_cycles", nround, e.rnd);
        chk("renorm_shift", rw_s, e.renorm ? 1 : 0);
        chk("renorm_inc", rw_i, e.renorm ? 1 : 0);
      end
    end
  end
  function automatic logic [22:0] outs();
    return {sinalMuxFP1, sinalMuxFP2, sinalShiftRes, sinalIncOrDec, sinalRound, ocupado, pronto, resultado_zero};
  endfunction
  task automatic wait_pronto();
    int n = 0;
    while (!pronto && n < 40) begin @(negedge clock); n++; end
    if (!pronto) chk("pronto_timeout", 0, 1);
  endtask
  task automatic run(input logic [53:0] u, input logic [25:0] rf, input bit hold);
    @(negedge clock);
    ula = u; round_fract = rf; iniciar = 1;
    q.push_back(model(u, rf));
    wait_pronto();
    if (!hold) iniciar = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [53:0] u, r;
    int pos, n;
    bit hold;
    repeat (3) @(negedge clock);
    chk("reset_outputs", outs(), 0);
    reset = 0;
    run((54'd1 << 46) | 54'h0_2A5F_1234_5678, 26'h0, 0);
    run((54'd1 << 47) | (54'd1 << 46), 26'h0, 0);
    run((54'd1 << 44) | 54'h1F, 26'h1FF_FFFF, 0);
    run((54'd1 << 46) | 54'h77, 26'h200_0000, 1);
    run(54'd0, 26'h3FF_FFFF, 1);
    run(54'd1 << 53, 26'h0, 0);
    run(54'd1, 26'h200_0000, 0);
    @(negedge clock);
    u = (54'd1 << 45) | 54'h3;
    ula = u; round_fract = 26'h200_0000; iniciar = 1;
    q.push_back(model(u, 26'h200_0000));
    n = 0;
    while (!sinalRound && n < 20) begin @(negedge clock); n++; end
    chk("reached_arredonda", sinalRound, 1);
    reset = 1;
    void'(q.pop_back());
    @(negedge clock);
    chk("reset_midrun_outputs", outs(), 0);
    reset = 0;
    q.push_back(model(u, 26'h200_0000));
    wait_pronto();
    iniciar = 0;
    for (int t = 0; t < 40; t++) begin
      pos = $urandom_range(0, 57);
      r = 54'({$urandom, $urandom});
      u = pos > 53 ? 54'd0 : ((54'd1 << pos) | (r & ((54'd1 << pos) - 54'd1)));
      hold = 1'($urandom_range(0, 1));
      run(u, 26'($urandom), hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    iniciar = 0;
    repeat (6) @(negedge clock);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
